// File: rtl/arb2_4.sv
// Two-channel round-robin arbiter with one registered output stage.
// Feeds a 2:1 mux stage: sel=0 selects a, sel=1 selects b.
module arb2_4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] c,
  output logic             c_valid,
  input  logic             c_ready,
  output logic             sel,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic ptr_q;  // 0: A has priority on a tie, 1: B
  logic load;
  logic grant_a;
  logic grant_b;

  // Output stage is free when empty or being drained this cycle.
  assign load    = !c_valid || c_ready;
  assign grant_a = a_valid && (!b_valid || !ptr_q);
  assign grant_b = b_valid && (!a_valid || ptr_q);

  // Readys are forced low while reset is held so no word is lost upstream.
  assign a_ready = !rst && load && grant_a;
  assign b_ready = !rst && load && grant_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c       <= '0;
      c_valid <= 1'b0;
      sel     <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_a   <= '0;
      cnt_b   <= '0;
    end else if (load) begin
      if (grant_a) begin
        c       <= a;
        c_valid <= 1'b1;
        sel     <= 1'b0;
        ptr_q   <= 1'b1;
        if (cnt_a != CntMax) begin
          cnt_a <= cnt_a + 1'b1;
        end
      end else if (grant_b) begin
        c       <= b;
        c_valid <= 1'b1;
        sel     <= 1'b1;
        ptr_q   <= 1'b0;
        if (cnt_b != CntMax) begin
          cnt_b <= cnt_b + 1'b1;
        end
      end else begin
        c_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb2_4.sv
// Directed bench for arb2_4: vector table plus hand-written reset,
// saturation and asynchronous-reset sequences.
module tb_arb2_4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] b;
  logic       b_valid;
  logic       b_ready;
  logic [3:0] c;
  logic       c_valid;
  logic       c_ready;
  logic       sel;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int n_total;
  int n_pass;

  arb2_4 #(.WIDTH(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .c       (c),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .sel     (sel),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic       av;
    logic [3:0] b;
    logic       bv;
    logic       cr;
    logic       ar;      // expected a_ready before the edge
    logic       br;      // expected b_ready before the edge
    logic [3:0] c;       // expected registered outputs after the edge
    logic       cv;
    logic       sel;
    logic [7:0] ca;
    logic [7:0] cb;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] ia, input logic iav, input logic [3:0] ib,
                       input logic ibv, input logic icr);
    a       = ia;
    a_valid = iav;
    b       = ib;
    b_valid = ibv;
    c_ready = icr;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    // Fairness from reset, then idle, singles, backpressure, ignored data, ptr tie.
    vecs[0]  = '{4'h9, 1'b1, 4'hf, 1'b1, 1'b1, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 8'd1, 8'd0};
    vecs[1]  = '{4'h9, 1'b1, 4'hf, 1'b1, 1'b1, 1'b0, 1'b1, 4'hf, 1'b1, 1'b1, 8'd1, 8'd1};
    vecs[2]  = '{4'h9, 1'b1, 4'hf, 1'b1, 1'b1, 1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 8'd2, 8'd1};
    vecs[3]  = '{4'h9, 1'b1, 4'hf, 1'b1, 1'b1, 1'b0, 1'b1, 4'hf, 1'b1, 1'b1, 8'd2, 8'd2};
    vecs[4]  = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hf, 1'b0, 1'b1, 8'd2, 8'd2};
    vecs[5]  = '{4'h6, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 8'd3, 8'd2};
    vecs[6]  = '{4'h0, 1'b0, 4'hb, 1'b1, 1'b1, 1'b0, 1'b1, 4'hb, 1'b1, 1'b1, 8'd3, 8'd3};
    vecs[7]  = '{4'h5, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 4'hb, 1'b1, 1'b1, 8'd3, 8'd3};
    vecs[8]  = '{4'h5, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 4'hb, 1'b1, 1'b1, 8'd3, 8'd3};
    vecs[9]  = '{4'h5, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 4'hb, 1'b1, 1'b1, 8'd3, 8'd3};
    vecs[10] = '{4'h5, 1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 8'd4, 8'd3};
    vecs[11] = '{4'he, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 8'd4, 8'd3};
    vecs[12] = '{4'he, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 8'd4, 8'd3};
    vecs[13] = '{4'h2, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 8'd5, 8'd3};
    vecs[14] = '{4'h1, 1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 8'd5, 8'd4};

    // Reset held for two cycles with a pending source: readys must stay low.
    rst = 1'b1;
    drive(4'h3, 1'b1, 4'h4, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_c", 32'(c), 32'd0);
    check("idle_c_valid", 32'(c_valid), 32'd0);
    check("idle_sel", 32'(sel), 32'd0);
    check("idle_cnt_a", 32'(cnt_a), 32'd0);
    check("idle_cnt_b", 32'(cnt_b), 32'd0);
    check("idle_a_ready", 32'(a_ready), 32'd0);
    check("idle_b_ready", 32'(b_ready), 32'd0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].av, vecs[i].b, vecs[i].bv, vecs[i].cr);
      #1;
      check($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ar));
      check($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].br));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_c", i), 32'(c), 32'(vecs[i].c));
      check($sformatf("v%0d_c_valid", i), 32'(c_valid), 32'(vecs[i].cv));
      check($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
      check($sformatf("v%0d_cnt_a", i), 32'(cnt_a), 32'(vecs[i].ca));
      check($sformatf("v%0d_cnt_b", i), 32'(cnt_b), 32'(vecs[i].cb));
    end

    // Saturation: 300 back-to-back B grants from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    drive(4'h0, 1'b0, 4'h3, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("sat_cnt_b", 32'(cnt_b), 32'd255);
    check("sat_cnt_a", 32'(cnt_a), 32'd0);
    check("sat_b_ready", 32'(b_ready), 32'd1);
    @(posedge clk);
    #1;
    check("sat_cnt_b_hold", 32'(cnt_b), 32'd255);
    check("sat_c", 32'(c), 32'd3);
    check("sat_sel", 32'(sel), 32'd1);

    // Asynchronous reset mid-cycle while c holds a valid word.
    @(negedge clk);
    drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    #2;
    check("pre_arst_c_valid", 32'(c_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_c_valid", 32'(c_valid), 32'd0);
    check("arst_c", 32'(c), 32'd0);
    check("arst_cnt_b", 32'(cnt_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Pointer back at A: a tie must go to A.
    drive(4'h9, 1'b1, 4'hf, 1'b1, 1'b1);
    #1;
    check("post_arst_a_ready", 32'(a_ready), 32'd1);
    check("post_arst_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk);
    #1;
    check("post_arst_c", 32'(c), 32'h9);
    check("post_arst_sel", 32'(sel), 32'd0);
    check("post_arst_cnt_a", 32'(cnt_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
